// File: rtl/output_layer_sequencer.sv
// Output-layer sequencer: walks every output neuron through the shared MAC,
// adds its bias and tracks a signed running argmax to pick the winning class.
module output_layer_sequencer #(
  parameter int N_OUT  = 10,
  parameter int BIAS_W = 8,
  parameter int ACC_W  = 20,
  parameter int IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    mac_start,
  output logic [IDX_W-1:0]        mac_neuron,
  input  logic                    mac_done,
  input  logic [ACC_W-1:0]        mac_sum,
  input  logic [N_OUT*BIAS_W-1:0] bias_bus,
  output logic                    done,
  output logic [IDX_W-1:0]        class_idx,
  output logic [ACC_W:0]          max_score
);

  localparam int SC_W = ACC_W + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [SC_W-1:0]   r_score;
  logic [SC_W-1:0]   r_max;
  logic [IDX_W-1:0]  r_arg;
  logic [IDX_W-1:0]  r_class;
  logic [SC_W-1:0]   r_maxsc;

  logic [BIAS_W-1:0] w_bias;
  logic [SC_W-1:0]   w_score;
  logic              w_take;
  logic              w_last;
  logic [SC_W-1:0]   w_new_max;
  logic [IDX_W-1:0]  w_new_arg;

  assign w_bias  = bias_bus[r_idx*BIAS_W +: BIAS_W];
  // One guard bit: sum of two sign-extended operands cannot overflow
  assign w_score = SC_W'($signed(mac_sum)) + SC_W'($signed(w_bias));

  // Neuron 0 always loads the running max; strict '>' keeps the lower index on ties
  assign w_take    = (r_idx == '0) || ($signed(r_score) > $signed(r_max));
  assign w_last    = (r_idx == LAST);
  assign w_new_max = w_take ? r_score : r_max;
  assign w_new_arg = w_take ? r_idx : r_arg;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (mac_done) w_next = S_ACCUM;
      S_ACCUM: w_next = w_last ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_score <= '0;
      r_max   <= '0;
      r_arg   <= '0;
      r_class <= '0;
      r_maxsc <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx <= '0;
            r_max <= '0;
            r_arg <= '0;
          end
        end
        S_WAIT: begin
          if (mac_done) r_score <= w_score;
        end
        S_ACCUM: begin
          r_max <= w_new_max;
          r_arg <= w_new_arg;
          // Results land on entry to DONE so they are valid with the pulse
          if (w_last) begin
            r_class <= w_new_arg;
            r_maxsc <= w_new_max;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign mac_start  = (r_state == S_ISSUE);
  assign mac_neuron = mac_start ? r_idx : '0;
  assign done       = (r_state == S_DONE);
  assign class_idx  = r_class;
  assign max_score  = r_maxsc;

endmodule

// File: tb/tb_output_layer_sequencer.sv
// Bench for output_layer_sequencer: MAC model with latency L, argmax model,
// per-cycle compare process and directed scenarios with literal results.
module tb_output_layer_sequencer;

  localparam int N  = 10;
  localparam int BW = 8;
  localparam int AW = 20;
  localparam int IW = 4;

  logic            clk = 0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            mac_start;
  logic [IW-1:0]   mac_neuron;
  logic            mac_done = 0;
  logic [AW-1:0]   mac_sum = '0;
  logic [N*BW-1:0] bias_bus;
  logic            done;
  logic [IW-1:0]   class_idx;
  logic [AW:0]     max_score;

  output_layer_sequencer #(
    .N_OUT(N), .BIAS_W(BW), .ACC_W(AW), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .mac_start(mac_start), .mac_neuron(mac_neuron),
    .mac_done(mac_done), .mac_sum(mac_sum), .bias_bus(bias_bus),
    .done(done), .class_idx(class_idx), .max_score(max_score)
  );

  always #5 clk = ~clk;

  int t_sum [N];
  int t_bias[N];
  int L = 2;
  int hold_extra = 0;
  bit spur = 0;

  int checks = 0;
  int errors = 0;

  always_comb begin
    bias_bus = '0;
    for (int k = 0; k < N; k++) bias_bus[k*BW +: BW] = t_bias[k][BW-1:0];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(output int c, output int m);
    int s;
    c = 0;
    m = 0;
    for (int k = 0; k < N; k++) begin
      s = t_sum[k] + t_bias[k];
      if (k == 0 || s > m) begin
        m = s;
        c = k;
      end
    end
  endfunction

  // Shared MAC model: result appears L+1 cycles after the request cycle
  int  m_cnt = 0;
  int  m_hold = 0;
  int  m_nb = 0;
  bit  m_pend = 0;
  always @(negedge clk) begin
    bit md;
    md = 0;
    if (m_hold > 0) begin
      md = 1;
      m_hold--;
    end
    if (m_pend) begin
      m_cnt++;
      if (m_cnt == L + 1) begin
        md = 1;
        mac_sum = t_sum[m_nb][AW-1:0];
        m_pend = 0;
        m_hold = hold_extra;
      end
    end
    if (mac_start === 1'b1) begin
      m_pend = 1;
      m_cnt = 0;
      m_nb = int'(mac_neuron);
    end
    if (spur) begin
      md = 1;
      spur = 0;
    end
    mac_done = md;
  end

  // Compare process
  bit exp_busy = 0;
  bit prev_done = 0;
  int exp_n = 0;
  int exp_class = 0;
  int exp_max = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int lat_last = 0;
  int ms_cnt = 0;
  int done_cnt = 0;
  int last_class = 0;
  int last_max = 0;

  always begin
    int c, m;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      exp_busy = 0;
      prev_done = 0;
      exp_n = 0;
      exp_class = 0;
      exp_max = 0;
      chk("rst_quiet", int'({busy, done, mac_start}), 0);
    end else begin
      if (!exp_busy) begin
        if (start) begin
          exp_busy = 1;
          acc_cyc = cyc;
          exp_n = 0;
        end
      end else if (prev_done) begin
        exp_busy = 0;
      end
      prev_done = done;
      chk("busy", int'(busy), int'(exp_busy));
      if (mac_start) begin
        ms_cnt++;
        chk("mac_neuron", int'(mac_neuron), exp_n);
        exp_n++;
      end
      if (done) begin
        done_cnt++;
        chk("done_while_busy", int'(exp_busy), 1);
        model(c, m);
        exp_class = c;
        exp_max = m;
        lat_last = cyc - acc_cyc + 2;
        chk("latency", lat_last, N * (3 + L) + 2);
        last_class = int'(class_idx);
        last_max = int'($signed(max_score));
      end
    end
    chk("class_idx", int'(class_idx), exp_class);
    chk("max_score", int'($signed(max_score)), exp_max);
  end

  int run_ms, run_done;

  task automatic do_run(input bit abuse, input int abort_n);
    int ms0, d0, t;
    bit pulse, arm, fired;
    ms0 = ms_cnt;
    d0 = done_cnt;
    pulse = 0;
    arm = 0;
    fired = 0;
    if (abuse) begin
      @(posedge clk);
      #1 spur = 1;
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    t = 0;
    while (done_cnt == d0 && !fired && t < 3000) begin
      @(negedge clk);
      t++;
      start = pulse;
      pulse = 0;
      if (rst) begin
        rst = 0;
        fired = 1;
      end else if (arm) begin
        rst = 1;
        arm = 0;
      end
      if (abuse && mac_start && mac_neuron == 2) pulse = 1;
      if (abort_n >= 0 && mac_start && int'(mac_neuron) == abort_n) arm = 1;
    end
    if (t >= 3000) chk("run_timeout", t, 0);
    repeat (6) @(negedge clk);
    run_ms = ms_cnt - ms0;
    run_done = done_cnt - d0;
  endtask

  initial begin
    rst = 1;
    start = 1;
    for (int k = 0; k < N; k++) begin
      t_sum[k] = 0;
      t_bias[k] = 0;
    end
    repeat (2) @(negedge clk);
    chk("t1_busy", int'(busy), 0);
    chk("t1_done", int'(done), 0);
    chk("t1_mac_start", int'(mac_start), 0);
    chk("t1_class", int'(class_idx), 0);
    chk("t1_max", int'(max_score), 0);
    rst = 0;
    start = 0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < N; k++) t_sum[k] = 100 * k;
    do_run(0, -1);
    chk("t2_class", last_class, 9);
    chk("t2_max", last_max, 900);
    chk("t2_latency", lat_last, 52);
    chk("t2_pulses", run_ms, 10);

    for (int k = 0; k < N; k++) t_sum[k] = 50;
    t_bias[3] = 7;
    do_run(0, -1);
    chk("t3a_class", last_class, 3);
    chk("t3a_max", last_max, 57);
    t_bias[3] = -128;
    do_run(0, -1);
    chk("t3b_class", last_class, 0);
    chk("t3b_max", last_max, 50);

    for (int k = 0; k < N; k++) begin
      t_sum[k] = -20;
      t_bias[k] = 0;
    end
    do_run(0, -1);
    chk("t4a_class", last_class, 0);
    chk("t4a_max", last_max, -20);
    for (int k = 0; k < N; k++) begin
      t_sum[k] = -524288;
      t_bias[k] = -128;
    end
    do_run(0, -1);
    chk("t4b_class", last_class, 0);
    chk("t4b_max", last_max, -524416);

    for (int k = 0; k < N; k++) begin
      t_sum[k] = 100 * k;
      t_bias[k] = 0;
    end
    hold_extra = 2;
    do_run(1, -1);
    hold_extra = 0;
    chk("t5_pulses", run_ms, 10);
    chk("t5_dones", run_done, 1);
    chk("t5_class", last_class, 9);
    chk("t5_max", last_max, 900);

    do_run(0, 4);
    chk("t6_abort_dones", run_done, 0);
    repeat (10) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      t_sum[k] = (k == 6) ? 300 : 10 * k;
      t_bias[k] = (k == 8) ? 5 : 0;
    end
    do_run(0, -1);
    chk("t6_pulses", run_ms, 10);
    chk("t6_dones", run_done, 1);
    chk("t6_class", last_class, 6);
    chk("t6_max", last_max, 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
